// File: rtl/underflow_protection_if.sv
// Operand/result stream bundle for the saturating subtractor.
// Master drives operands and out_ready; slave (the subtractor) drives in_ready and results.
interface underflow_protection_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] floor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_uf;

    modport master (
        output in_valid, in1, in2, floor, out_ready,
        input  in_ready, out_valid, out, out_uf
    );

    modport slave (
        input  in_valid, in1, in2, floor, out_ready,
        output in_ready, out_valid, out, out_uf
    );
endinterface

// File: rtl/underflow_protection.sv
// Saturating subtractor out = in1 - in2 clamped at 0 (or at bus.floor with UNDERFLOW_FLOOR_EN), plus sticky flag/event counter.
// Latency 2 cycles, throughput 1/cycle.
// Backpressure: whole pipe stalls while out_valid & !out_ready; in_ready = !v2 | out_ready.
module underflow_protection #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    underflow_protection_if.slave bus,
    input  logic                 uf_clr,
    output logic                 uf_sticky,
    output logic [CNT_WIDTH-1:0] uf_count
);

    logic                 adv;
    logic                 below;
    logic [WIDTH-1:0]     clamp_val;
    logic                 uf_hs;

    logic                 v1_q, v1_d;
    logic                 borrow_q, borrow_d;
    logic [WIDTH-1:0]     diff_q, diff_d;
    logic                 v2_q, v2_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 out_uf_q, out_uf_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

`ifdef UNDERFLOW_FLOOR_EN
    logic [WIDTH-1:0]     floor_q, floor_d;

    always_comb begin
        floor_d   = adv ? bus.floor : floor_q;
        below     = borrow_q || (diff_q < floor_q);
        clamp_val = floor_q;
    end

    always_ff @(posedge clk) begin
        if (rst) floor_q <= '0;
        else     floor_q <= floor_d;
    end
`else
    // Floor is fixed at zero; the port is only folded into an unused net.
    logic unused_floor;
    assign unused_floor = ^bus.floor;

    always_comb begin
        below     = borrow_q;
        clamp_val = '0;
    end
`endif

    always_comb begin
        adv      = !v2_q || bus.out_ready;
        v1_d     = v1_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        v2_d     = v2_q;
        out_d    = out_q;
        out_uf_d = out_uf_q;
        if (adv) begin
            v1_d               = bus.in_valid;
            {borrow_d, diff_d} = {1'b0, bus.in1} - {1'b0, bus.in2};
            v2_d               = v1_q;
            out_d              = below ? clamp_val : diff_q;
            out_uf_d           = below;
        end
    end

    // Clear wins for the flag, but an underflow retired in the same cycle is still counted.
    always_comb begin
        uf_hs    = v2_q && bus.out_ready && out_uf_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        if (uf_clr) begin
            sticky_d = 1'b0;
            count_d  = uf_hs ? CNT_WIDTH'(1) : '0;
        end else if (uf_hs) begin
            sticky_d = 1'b1;
            if (!(&count_q)) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            v2_q     <= 1'b0;
            out_q    <= '0;
            out_uf_q <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            v1_q     <= v1_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            v2_q     <= v2_d;
            out_q    <= out_d;
            out_uf_q <= out_uf_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v2_q;
    assign bus.out       = out_q;
    assign bus.out_uf    = out_uf_q;
    assign uf_sticky     = sticky_q;
    assign uf_count      = count_q;

endmodule

// File: tb/tb_underflow_protection.sv
// Bench for underflow_protection (WIDTH=4, CNT_WIDTH=4): directed steps plus a random stream against a queue model.
module tb_underflow_protection;
    localparam int W    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          uf_clr;
    logic          uf_sticky;
    logic [CW-1:0] uf_count;

    always #5 clk = ~clk;

    underflow_protection_if #(.WIDTH(W)) bus ();

    underflow_protection #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .uf_clr    (uf_clr),
        .uf_sticky (uf_sticky),
        .uf_count  (uf_count)
    );

    typedef struct {
        int val;
        bit uf;
        int age;
    } item_t;

    item_t q[$];
    int    m_sticky = 0;
    int    m_count  = 0;
    int    floor_v  = 0;
    int    n_tests  = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Result of one operand pair, straight from the arithmetic definition.
    function automatic item_t ref_res(input int a, input int b);
        item_t it;
        int    fl;
`ifdef UNDERFLOW_FLOOR_EN
        fl = floor_v;
`else
        fl = 0;
`endif
        it.age = 1;
        if (a - b < fl) begin
            it.val = fl;
            it.uf  = 1'b1;
        end else begin
            it.val = a - b;
            it.uf  = 1'b0;
        end
        return it;
    endfunction

    // One clock: drive at negedge, check the visible state, then advance the model across the posedge.
    task automatic cycle(input bit r, input bit iv, input int a, input int b, input bit ordy, input bit clr);
        bit exp_ov, exp_rdy, hs_uf;
        rst           = r;
        bus.in_valid  = iv;
        bus.in1       = W'(a);
        bus.in2       = W'(b);
        bus.floor     = W'(floor_v);
        bus.out_ready = ordy;
        uf_clr        = clr;
        #1;
        exp_ov  = (q.size() > 0) && (q[0].age >= 2);
        exp_rdy = !exp_ov || ordy;
        chk("out_valid", bus.out_valid, exp_ov);
        chk("in_ready", bus.in_ready, exp_rdy);
        if (exp_ov) begin
            chk("out", bus.out, q[0].val);
            chk("out_uf", bus.out_uf, q[0].uf);
        end
        chk("uf_sticky", uf_sticky, m_sticky);
        chk("uf_count", uf_count, m_count);
        if (r) begin
            q.delete();
            m_sticky = 0;
            m_count  = 0;
        end else begin
            hs_uf = 1'b0;
            if (exp_ov && ordy) begin
                hs_uf = q[0].uf;
                void'(q.pop_front());
            end
            if (clr) begin
                m_sticky = 0;
                m_count  = hs_uf ? 1 : 0;
            end else if (hs_uf) begin
                m_sticky = 1;
                if (m_count < CMAX) m_count++;
            end
            if (exp_rdy) begin
                foreach (q[i]) q[i].age++;
                if (iv) q.push_back(ref_res(a, b));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.floor     = '0;
        bus.out_ready = 1'b1;
        uf_clr        = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_out_uf", bus.out_uf, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Basic: 7-2 with 2-cycle latency
        cycle(0, 1, 7, 2, 1, 0);
        chk("basic_early_valid", bus.out_valid, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_out", bus.out, 5);
        chk("basic_uf", bus.out_uf, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("basic_count", uf_count, 0);

        // Underflow, then equal operands
        cycle(0, 1, 2, 15, 1, 0);
        cycle(0, 1, 5, 5, 1, 0);
        chk("uf_out", bus.out, 0);
        chk("uf_flag", bus.out_uf, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("uf_sticky_set", uf_sticky, 1);
        chk("uf_count_1", uf_count, 1);
        chk("eq_out", bus.out, 0);
        chk("eq_uf", bus.out_uf, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("eq_count", uf_count, 1);

        // Backpressure: 3 stall cycles once the first result is up
        cycle(0, 1, 9, 3, 1, 0);
        cycle(0, 1, 1, 4, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8, 8, 0, 0);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold", bus.out, 6);
        chk("bp_hold_valid", bus.out_valid, 1);
        cycle(0, 1, 8, 8, 1, 0);
        chk("bp_r2_out", bus.out, 0);
        chk("bp_r2_uf", bus.out_uf, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("bp_r3_out", bus.out, 0);
        chk("bp_r3_uf", bus.out_uf, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("bp_drained", bus.out_valid, 0);
        chk("bp_count", uf_count, 2);

        // Counter saturation
        for (int i = 0; i < 17; i++) cycle(0, 1, i % 15, 15, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("sat_count", uf_count, 15);
        chk("sat_sticky", uf_sticky, 1);

        // Clear coinciding with an underflow handshake, then clear alone
        cycle(0, 1, 3, 9, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("clr_hs_sticky", uf_sticky, 0);
        chk("clr_hs_count", uf_count, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("clr_count", uf_count, 0);
        chk("clr_sticky", uf_sticky, 0);

        // Random stream with random backpressure, floor and clears
        for (int i = 0; i < 400; i++) begin
            floor_v = $urandom_range(0, 15);
            cycle(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end
        floor_v = 0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);

        // Reset with both stages full
        cycle(0, 1, 2, 5, 1, 0);
        cycle(0, 1, 7, 1, 1, 0);
        cycle(1, 1, 4, 9, 0, 0);
        chk("rmid_valid", bus.out_valid, 0);
        chk("rmid_out", bus.out, 0);
        chk("rmid_count", uf_count, 0);
        chk("rmid_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("rmid_no_stale", bus.out_valid, 0);

`ifdef UNDERFLOW_FLOOR_EN
        // Programmable floor of 3
        floor_v = 3;
        cycle(0, 1, 9, 7, 1, 0);
        cycle(0, 1, 9, 6, 1, 0);
        cycle(0, 1, 1, 4, 1, 0);
        chk("fl_a_out", bus.out, 3);
        chk("fl_a_uf", bus.out_uf, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("fl_b_out", bus.out, 3);
        chk("fl_b_uf", bus.out_uf, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("fl_c_out", bus.out, 3);
        chk("fl_c_uf", bus.out_uf, 1);
        cycle(0, 0, 0, 0, 1, 0);
        floor_v = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
